fft_window_packer: RTL and testbench

- Downstream neighbour of the overlapped-frame ping-pong buffer.
- Takes its 256-sample frame stream (data, valid, last) and applies a programmable window coefficient to each sample.
- Formats each result as a complex AXI-Stream word with tlast for the FFT core.
- Absorbs FFT backpressure in a small output FIFO. The upstream source cannot be stalled.

---
 rtl/fft_window_packer_if.sv | 21 ++
 rtl/fft_window_packer.sv | 182 ++++++++++++++++++
 tb/tb_fft_window_packer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_window_packer_if.sv
// Frame-sample input and windowed complex output stream bundle.
// The sample side has no ready: the packer must take or drop every sample.
interface fft_window_packer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (
    output s_data, s_valid, s_last, m_tready,
    input  m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    input  s_data, s_valid, s_last, m_tready,
    output m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/fft_window_packer.sv
// Windows frame samples with a coefficient RAM and packs them as complex
// stream words for the FFT, buffering backpressure in a small FIFO.
module fft_window_packer #(
  parameter int          FFT_POINT = 256,
  parameter int          OUT_DEPTH = 16,
  parameter logic [15:0] COEF_INIT = 16'h7FFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  fft_window_packer_if.slave        bus,
  input  logic                      coef_wr_en,
  input  logic [7:0]                coef_wr_addr,
  input  logic [15:0]               coef_wr_data,
  output logic                      frame_err,
  output logic                      overflow,
  input  logic                      clr_flags,
  output logic                      busy
);
  localparam int IW = $clog2(FFT_POINT);
  localparam int AW = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {
    IDLE, ALIGN, RUN, FINISH
  } state_t;

  state_t          state_q;
  logic            busy_q;
  logic [IW-1:0]   idx_q, idx_d;
  logic            acc, at_end, eof, err;

  assign acc    = bus.s_valid &&
                  (state_q == RUN || state_q == FINISH);
  assign at_end = idx_q == IW'(FFT_POINT - 1);
  assign eof    = bus.s_last || at_end;
  assign err    = bus.s_last ^ at_end;
  assign idx_d  = !acc ? idx_q :
                  eof  ? '0    : idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      idx_q <= idx_d;
      unique case (state_q)
        IDLE: if (enable) begin
          state_q <= ALIGN;
          busy_q  <= 1'b1;
        end
        ALIGN: if (bus.s_valid && bus.s_last) begin
          state_q <= RUN;
        end
        RUN: if (!enable) begin
          // decide on the post-update index so a closing sample ends here
          state_q <= (idx_d == '0) ? IDLE : FINISH;
          busy_q  <= idx_d != '0;
        end
        FINISH: if (acc && eof) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  logic [15:0] coef_mem [FFT_POINT] = '{default: COEF_INIT};
  logic [15:0] coef_q;

  logic          s0_v_q, s1_v_q, s2_v_q;
  logic [15:0]   s0_data_q, s1_data_q, s2_real_q;
  logic [IW-1:0] s0_idx_q;
  logic          s0_last_q, s1_last_q, s2_last_q;

  // read-before-write: a same-address write shows up next access
  always_ff @(posedge clk) begin
    if (coef_wr_en) begin
      coef_mem[coef_wr_addr[IW-1:0]] <= coef_wr_data;
    end
    coef_q <= coef_mem[s0_idx_q];
  end

  logic signed [32:0] prod, rnd;
  logic [15:0]        sat;

  always_comb begin
    prod = $signed({{17{s1_data_q[15]}}, s1_data_q}) *
           $signed({17'b0, coef_q});
    rnd  = (prod + 33'sd16384) >>> 15;
    if (rnd > 33'sd32767) begin
      sat = 16'h7FFF;
    end else if (rnd < -33'sd32768) begin
      sat = 16'h8000;
    end else begin
      sat = rnd[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_v_q    <= 1'b0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s0_data_q <= '0;
      s0_idx_q  <= '0;
      s0_last_q <= 1'b0;
      s1_data_q <= '0;
      s1_last_q <= 1'b0;
      s2_real_q <= '0;
      s2_last_q <= 1'b0;
    end else begin
      s0_v_q <= acc;
      if (acc) begin
        s0_data_q <= bus.s_data;
        s0_idx_q  <= idx_q;
        s0_last_q <= eof;
      end
      s1_v_q    <= s0_v_q;
      s1_data_q <= s0_data_q;
      s1_last_q <= s0_last_q;
      s2_v_q    <= s1_v_q;
      s2_real_q <= sat;
      s2_last_q <= s1_last_q;
    end
  end

  logic [16:0]   fifo_mem [OUT_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          pop, full, wr_ok, ovf_set;
  logic          frame_err_q, overflow_q;
  logic [16:0]   head;

  assign bus.m_tvalid = cnt_q != '0;
  assign pop          = bus.m_tvalid && bus.m_tready;
  assign full         = cnt_q == (AW+1)'(OUT_DEPTH);
  assign wr_ok        = s2_v_q && (!full || pop);
  assign ovf_set      = s2_v_q && full && !pop;
  assign head         = fifo_mem[rd_q];
  assign bus.m_tdata  = {16'h0000, head[16:1]};
  assign bus.m_tlast  = bus.m_tvalid && head[0];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      fifo_mem[wr_q] <= {s2_real_q, s2_last_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (wr_ok && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!wr_ok && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
      frame_err_q <= (acc && err) || (frame_err_q && !clr_flags);
      overflow_q  <= ovf_set || (overflow_q && !clr_flags);
    end
  end

  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_fft_window_packer.sv
// Directed bench for fft_window_packer: framing, windowing arithmetic,
// FIFO backpressure/overflow, enable shutdown and mid-frame reset.
module tb_fft_window_packer;
  logic        clk = 1'b0;
  logic        rst_n, enable, coef_wr_en, clr_flags;
  logic [7:0]  coef_wr_addr;
  logic [15:0] coef_wr_data;
  logic        frame_err, overflow, busy;

  fft_window_packer_if bus();

  fft_window_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .bus          (bus),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .clr_flags    (clr_flags),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int imag_bad = 0;
  logic [16:0] got [$];

  always @(negedge clk) begin
    if (rst_n && bus.m_tvalid && bus.m_tready) begin
      got.push_back({bus.m_tlast, bus.m_tdata[15:0]});
      if (bus.m_tdata[31:16] != 16'h0000) imag_bad++;
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] coef;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_coef(input logic [7:0] a, input logic [15:0] d);
    coef_wr_en   = 1'b1;
    coef_wr_addr = a;
    coef_wr_data = d;
    tick(1);
    coef_wr_en   = 1'b0;
  endtask

  task automatic send_frame(input int len, input int last_at,
                            input int pos, input logic [15:0] val,
                            input bit ramp, input logic [15:0] ofs);
    for (int i = 0; i < len; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = (i == pos) ? val :
                    (ramp ? ofs + 16'(i) : 16'h0000);
      bus.s_last  = (i == last_at);
      tick(1);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  function automatic logic [16:0] word(input int k);
    if (k < got.size()) return got[k];
    return 17'h1_DEAD;
  endfunction

  initial begin
    int base;
    int errs;
    vecs[0] = '{8'd5,   16'h4000, 16'h7FFF, 16'h4000};
    vecs[1] = '{8'd6,   16'hFFFF, 16'h7FFF, 16'h7FFF};
    vecs[2] = '{8'd6,   16'hFFFF, 16'h8000, 16'h8000};
    vecs[3] = '{8'd7,   16'h4000, 16'h0001, 16'h0001};
    vecs[4] = '{8'd7,   16'h4000, 16'hFFFF, 16'h0000};
    vecs[5] = '{8'd8,   16'h4000, 16'h8000, 16'hC000};
    vecs[6] = '{8'd9,   16'h0000, 16'h1234, 16'h0000};
    vecs[7] = '{8'd10,  16'hFFFF, 16'hFFFF, 16'hFFFE};
    vecs[8] = '{8'd255, 16'h8000, 16'h7FFF, 16'h7FFF};
    vecs[9] = '{8'd0,   16'h2000, 16'h0100, 16'h0040};

    rst_n = 1'b0; enable = 1'b0; clr_flags = 1'b0;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0;
    bus.m_tready = 1'b1;
    tick(3);
    chk("rst_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_tlast", 32'(bus.m_tlast), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(1);

    enable = 1'b1;
    tick(1);
    chk("t1_busy_align", 32'(busy), 32'd1);
    send_frame(256, 255, -1, 16'h0, 1'b1, 16'h0);
    tick(5);
    chk("t1_frame1_dropped", 32'(got.size()), 32'd0);
    base = got.size();
    for (int i = 0; i < 256; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = (i == 0) ? 16'h4000 : 16'(i);
      bus.s_last  = (i == 255);
      tick(1);
      if (i == 2) chk("t1_lat_not_early", 32'(bus.m_tvalid), 32'd0);
      if (i == 3) begin
        chk("t1_lat_valid", 32'(bus.m_tvalid), 32'd1);
        chk("t1_lat_data", bus.m_tdata, 32'h0000_4000);
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    tick(6);
    chk("t1_word_count", 32'(got.size() - base), 32'd256);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (word(base + i) !== {i == 255, (i == 0) ? 16'h4000 : 16'(i)})
        errs++;
    end
    chk("t1_words_tlast", 32'(errs), 32'd0);
    chk("t1_frame_err", 32'(frame_err), 32'd0);

    for (int v = 0; v < 10; v++) begin
      wr_coef(vecs[v].addr, vecs[v].coef);
      base = got.size();
      send_frame(256, 255, int'(vecs[v].addr), vecs[v].data,
                 1'b0, 16'h0);
      tick(6);
      chk($sformatf("t2_vec%0d", v),
          32'(word(base + int'(vecs[v].addr))),
          32'({vecs[v].addr == 8'd255, vecs[v].exp}));
      wr_coef(vecs[v].addr, 16'h7FFF);
    end

    wr_coef(8'd0, 16'h4000);
    base = got.size();
    send_frame(100, 99, -1, 16'h0, 1'b1, 16'h0);
    chk("t3_frame_err_set", 32'(frame_err), 32'd1);
    send_frame(256, 255, 0, 16'h7FFF, 1'b0, 16'h0);
    tick(6);
    chk("t3_short_tlast", 32'(word(base + 99)), 32'({1'b1, 16'd99}));
    chk("t3_resync_coef0", 32'(word(base + 100)),
        32'({1'b0, 16'h4000}));
    chk("t3_word_count", 32'(got.size() - base), 32'd356);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    chk("t3_frame_err_clr", 32'(frame_err), 32'd0);
    wr_coef(8'd0, 16'h7FFF);

    bus.m_tready = 1'b0;
    send_frame(20, -1, -1, 16'h0, 1'b1, 16'h0100);
    tick(4);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_stall_valid", 32'(bus.m_tvalid), 32'd1);
    chk("t4_stall_head", bus.m_tdata, 32'h0000_0100);
    tick(3);
    chk("t4_stall_hold", bus.m_tdata, 32'h0000_0100);
    base = got.size();
    bus.m_tready = 1'b1;
    tick(20);
    chk("t4_drain_count", 32'(got.size() - base), 32'd16);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (word(base + i) !== {1'b0, 16'h0100 + 16'(i)}) errs++;
    end
    chk("t4_drain_order", 32'(errs), 32'd0);
    send_frame(236, 235, -1, 16'h0, 1'b0, 16'h0);
    tick(6);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    chk("t4_overflow_clr", 32'(overflow), 32'd0);

    send_frame(40, -1, -1, 16'h0, 1'b1, 16'h0);
    enable = 1'b0;
    tick(1);
    chk("t5_busy_finish", 32'(busy), 32'd1);
    send_frame(215, -1, -1, 16'h0, 1'b1, 16'h0);
    chk("t5_busy_hold", 32'(busy), 32'd1);
    send_frame(1, 0, -1, 16'h0, 1'b0, 16'h0);
    chk("t5_idle", 32'(busy), 32'd0);
    tick(6);
    base = got.size();
    send_frame(256, 255, -1, 16'h0, 1'b1, 16'h0);
    tick(6);
    chk("t5_idle_drops", 32'(got.size() - base), 32'd0);

    wr_coef(8'd3, 16'h4000);
    enable = 1'b1;
    tick(1);
    send_frame(256, 255, -1, 16'h0, 1'b1, 16'h0);
    bus.m_tready = 1'b0;
    send_frame(5, 4, 3, 16'h7FFF, 1'b0, 16'h0);
    tick(4);
    chk("t6_pre_err", 32'(frame_err), 32'd1);
    chk("t6_pre_valid", 32'(bus.m_tvalid), 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("t6_rst_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("t6_rst_tlast", 32'(bus.m_tlast), 32'd0);
    chk("t6_rst_frame_err", 32'(frame_err), 32'd0);
    chk("t6_rst_overflow", 32'(overflow), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    bus.m_tready = 1'b1;
    tick(1);
    send_frame(256, 255, -1, 16'h0, 1'b1, 16'h0);
    base = got.size();
    send_frame(256, 255, 3, 16'h7FFF, 1'b0, 16'h0);
    tick(6);
    chk("t6_ram_kept", 32'(word(base + 3)), 32'({1'b0, 16'h4000}));
    chk("t6_word_count", 32'(got.size() - base), 32'd256);
    chk("imag_zero", 32'(imag_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
